// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register with a 2-entry skid buffer, synchronous flush and 1-cycle latency.
// Optional perf counters (stall_cnt, bubble_cnt) are enabled by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int              DATA_W = 256,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;
  logic              load_main;
  logic              load_skid;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign occupancy = state;
  assign out_data  = out_valid ? main_data : BUBBLE;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main = 1'b1;
          state_nxt = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush kills everything, including a payload offered this cycle.
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Payload registers only move on an accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_main) main_data <= (state == FULL) ? skid_data : in_data;
      if (load_skid) skid_data <= in_data;
    end
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios then random traffic against a queue-based model.
module tb_pipe_stage_buf;
  localparam int DW = 32;
  localparam logic [DW-1:0] BUB = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .BUBBLE(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  longint        stall_m  = 0;
  longint        bubble_m = 0;

  // Everything the DUT actually hands downstream.
  always @(posedge clk)
    if (out_valid === 1'b1 && out_ready === 1'b1) obs_q.push_back(out_data);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic fl, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
    bit in_fire_m, out_fire_m;
    rst = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check("out_data", 64'(out_data), 64'((mq.size() > 0) ? mq[0] : BUB));
    check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
`ifdef PIPE_STAGE_BUF_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    check("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
`endif
    in_fire_m  = iv && (mq.size() < 2);
    out_fire_m = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      stall_m = 0; bubble_m = 0;
    end else begin
      if (mq.size() > 0 && !ordy && stall_m < 64'hFFFF_FFFF) stall_m++;
      if (mq.size() == 0 && bubble_m < 64'hFFFF_FFFF) bubble_m++;
    end
    if (out_fire_m) exp_q.push_back(mq.pop_front());
    if (r || fl) mq.delete();
    else if (in_fire_m) mq.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state is checked by the first idle cycle.
    cycle(0, 0, 0, 32'h0, 0);

    // Streaming with downstream always ready.
    cycle(0, 0, 1, 32'h11, 1);
    cycle(0, 0, 1, 32'h22, 1);
    cycle(0, 0, 1, 32'h33, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Backpressure fills the skid, then drains in order.
    cycle(0, 0, 1, 32'hA, 0);
    cycle(0, 0, 1, 32'hB, 0);
    cycle(0, 0, 1, 32'hE, 0);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Flush while full and offering 0xC.
    cycle(0, 0, 1, 32'hA1, 0);
    cycle(0, 0, 1, 32'hB1, 0);
    cycle(0, 1, 1, 32'hC, 0);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Flush together with an out_fire: entry delivered once.
    cycle(0, 0, 1, 32'hD, 0);
    cycle(0, 1, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

`ifdef PIPE_STAGE_BUF_PERF_EN
    cycle(1, 0, 0, 32'h0, 0);
    cycle(0, 0, 1, 32'h55, 0);
    repeat (5) cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 32'h0, 0);
    repeat (3) cycle(0, 0, 0, 32'h0, 0);
    dut.stall_cnt = 32'hFFFF_FFFD;  stall_m  = 64'hFFFF_FFFD;
    dut.bubble_cnt = 32'hFFFF_FFFD; bubble_m = 64'hFFFF_FFFD;
    cycle(0, 0, 1, 32'h66, 0);
    repeat (5) cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 32'h0, 0);
    repeat (5) cycle(0, 0, 0, 32'h0, 0);
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
            DW'($urandom), ($urandom % 3) != 0);
    end

    check("delivered_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("delivered_data", 64'(obs_q[i]), 64'(exp_q[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
